// File: rtl/queue_ptr_ctrl.sv
// Pointer/occupancy controller for a single-port RAM byte queue.
// One RAM access (write or read) per two cycles, alternating on contention.
module queue_ptr_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              addr_sel,
  output logic              ram_we,
  output logic              ram_re,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t state;
  logic   last_wr;
  logic   push_ok;
  logic   pop_ok;
  logic   grant_wr;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // On a tie the op not performed last wins; last_wr=0 means last op was RD.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    grant_wr = push_ok && (!pop_ok || !last_wr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_wr  <= 1'b0;
      addr_sel <= 1'b0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      push_ack <= 1'b0;
      pop_ack  <= 1'b0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      addr_sel <= 1'b0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      push_ack <= 1'b0;
      pop_ack  <= 1'b0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      case (state)
        IDLE: begin
          ovf <= push && full;
          udf <= pop && empty;
          if (grant_wr) begin
            state    <= WR;
            addr_sel <= 1'b1;
            ram_we   <= 1'b1;
            push_ack <= 1'b1;
          end else if (pop_ok) begin
            state   <= RD;
            ram_re  <= 1'b1;
            pop_ack <= 1'b1;
          end
        end
        WR: begin
          wr_ptr  <= wr_ptr + PTR_ONE;
          count   <= count + CNT_ONE;
          last_wr <= 1'b1;
          state   <= IDLE;
        end
        RD: begin
          rd_ptr   <= rd_ptr + PTR_ONE;
          count    <= count - CNT_ONE;
          last_wr  <= 1'b0;
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
